// File: rtl/game_genie_loader_if.sv
// Wishbone pipelined bus bundle between the cheat loader and the cheat table.
interface game_genie_loader_if;
  logic         o_wb_cyc;
  logic         o_wb_stb;
  logic         o_wb_we;
  logic [1:0]   o_wb_addr;
  logic [128:0] o_wb_odata;
  logic         i_wb_ack;
  logic         i_wb_stall;
  logic         i_wb_err;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_odata,
    input  i_wb_ack, i_wb_stall, i_wb_err
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_odata,
    output i_wb_ack, i_wb_stall, i_wb_err
  );
endinterface

// File: rtl/game_genie_loader.sv
// Game Genie code loader: collects ASCII cheat letters, decodes a 6 or 8
// letter code into address/replace/compare, and writes it into one of four
// cheat slots with a single Wishbone pipelined write.
module game_genie_loader #(
  parameter int TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_char_valid,
  input  logic [7:0]         i_char,
  output logic               o_char_ready,
  input  logic               i_clear,
  output logic               o_done,
  output logic               o_error,
  output logic               o_cheats_loaded,
  game_genie_loader_if.master wb
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {COLLECT, DECODE, REQ, WAIT} state_t;

  state_t         state, state_next;
  logic [3:0]     nib [8];
  logic [3:0]     count;
  logic           bad;
  logic [1:0]     slot;
  logic [TW-1:0]  timer;
  logic [128:0]   odata_q;
  logic [128:0]   packed_word;

  logic [7:0]     upper;
  logic           is_letter;
  logic           is_term;
  logic [3:0]     letter_nib;

  logic           code_ok;
  logic           code_bad;
  logic           wb_done;
  logic           wb_fail;

  logic [3:0]     n_last;
  logic           dec_en;
  logic [15:0]    dec_addr;
  logic [7:0]     dec_rep;
  logic [7:0]     dec_cmp;

  // Fold lower case onto upper case and map the sixteen code letters to nibbles
  always_comb begin
    upper = i_char;
    if (i_char >= 8'h61 && i_char <= 8'h7a) upper = i_char - 8'h20;
    is_term    = (i_char == 8'h0a) || (i_char == 8'h0d);
    is_letter  = 1'b1;
    letter_nib = 4'd0;
    case (upper)
      "A": letter_nib = 4'd0;
      "P": letter_nib = 4'd1;
      "Z": letter_nib = 4'd2;
      "L": letter_nib = 4'd3;
      "G": letter_nib = 4'd4;
      "I": letter_nib = 4'd5;
      "T": letter_nib = 4'd6;
      "Y": letter_nib = 4'd7;
      "E": letter_nib = 4'd8;
      "O": letter_nib = 4'd9;
      "X": letter_nib = 4'd10;
      "U": letter_nib = 4'd11;
      "K": letter_nib = 4'd12;
      "S": letter_nib = 4'd13;
      "V": letter_nib = 4'd14;
      "N": letter_nib = 4'd15;
      default: is_letter = 1'b0;
    endcase
  end

  // Unscramble the stored nibbles into the bus word for the current slot
  always_comb begin
    dec_en   = (count == 4'd8);
    n_last   = dec_en ? nib[7] : nib[5];
    dec_addr = {1'b1, nib[3][2:0], nib[4][3], nib[5][2:0],
                nib[1][3], nib[2][2:0], nib[3][3], nib[4][2:0]};
    dec_rep  = {nib[0][3], nib[1][2:0], n_last[3], nib[0][2:0]};
    dec_cmp  = dec_en ? {nib[6][3], nib[7][2:0], nib[5][3], nib[6][2:0]} : 8'h00;
    packed_word           = '0;
    packed_word[111:104]  = {6'd0, slot} + 8'd1;
    packed_word[96]       = dec_en;
    packed_word[79:64]    = dec_addr;
    packed_word[39:32]    = dec_cmp;
    packed_word[7:0]      = dec_rep;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= COLLECT;
    else            state <= state_next;
  end

  // Next state, bus controls and completion events
  always_comb begin
    state_next     = state;
    o_char_ready   = 1'b0;
    wb.o_wb_cyc    = 1'b0;
    wb.o_wb_stb    = 1'b0;
    code_ok        = 1'b0;
    code_bad       = 1'b0;
    wb_done        = 1'b0;
    wb_fail        = 1'b0;
    case (state)
      COLLECT: begin
        o_char_ready = 1'b1;
        if (i_char_valid && is_term && count != 4'd0) begin
          if ((count == 4'd6 || count == 4'd8) && !bad) begin
            code_ok    = 1'b1;
            state_next = DECODE;
          end else begin
            code_bad = 1'b1;
          end
        end
      end
      DECODE: state_next = REQ;
      REQ: begin
        wb.o_wb_cyc = 1'b1;
        wb.o_wb_stb = 1'b1;
        if (!wb.i_wb_stall) begin
          if (wb.i_wb_err) begin
            wb_fail    = 1'b1;
            state_next = COLLECT;
          end else if (wb.i_wb_ack) begin
            wb_done    = 1'b1;
            state_next = COLLECT;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        wb.o_wb_cyc = 1'b1;
        if (wb.i_wb_err) begin
          wb_fail    = 1'b1;
          state_next = COLLECT;
        end else if (wb.i_wb_ack) begin
          wb_done    = 1'b1;
          state_next = COLLECT;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          wb_fail    = 1'b1;
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
    wb.o_wb_we   = wb.o_wb_cyc;
    wb.o_wb_addr = wb.o_wb_cyc ? 2'h1 : 2'h0;
  end

  assign wb.o_wb_odata = odata_q;

  // Letter buffer, slot bookkeeping, response timer and result pulses
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 8; i++) nib[i] <= 4'd0;
      count           <= 4'd0;
      bad             <= 1'b0;
      slot            <= 2'd0;
      timer           <= '0;
      odata_q         <= '0;
      o_done          <= 1'b0;
      o_error         <= 1'b0;
      o_cheats_loaded <= 1'b0;
    end else begin
      o_done  <= wb_done;
      o_error <= wb_fail || code_bad;
      timer   <= (state == WAIT) ? timer + TW'(1) : '0;

      if (state == COLLECT && i_char_valid) begin
        if (is_term) begin
          if (!code_ok) begin
            count <= 4'd0;
            bad   <= 1'b0;
          end
        end else if (is_letter) begin
          if (count == 4'd8) begin
            bad <= 1'b1;
          end else begin
            nib[count[2:0]] <= letter_nib;
            count           <= count + 4'd1;
          end
        end else begin
          bad <= 1'b1;
        end
      end

      if (state == DECODE) begin
        odata_q <= packed_word;
        count   <= 4'd0;
        bad     <= 1'b0;
      end

      if (wb_done) begin
        slot            <= (i_clear ? 2'd0 : slot) + 2'd1;
        o_cheats_loaded <= 1'b1;
      end else if (i_clear) begin
        slot            <= 2'd0;
        o_cheats_loaded <= 1'b0;
      end
    end
  end

endmodule

// File: doc/game_genie_loader.md
GAME_GENIE_LOADER -- requirements
Module: game_genie_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles to wait for i_wb_ack/i_wb_err after the request is accepted.
REQ-002 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_char_valid  in  1  ASCII character strobe.
REQ-005 SHALL have port i_char  in  8  ASCII character.
REQ-006 SHALL have port o_char_ready  out  1  character accepted when valid&&ready.
REQ-007 SHALL have port i_clear  in  1  return slot counter to 1 and drop o_cheats_loaded.
REQ-008 SHALL have ports o_done and o_error  out  1 each  single-cycle completion/failure pulses.
REQ-009 SHALL have port o_cheats_loaded  out  1  set after first successful write.
REQ-010 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master controls.
REQ-011 SHALL have ports o_wb_addr  out  2  and o_wb_odata  out  129  Wishbone address/data.
REQ-012 SHALL have ports i_wb_ack, i_wb_stall, i_wb_err  in  1 each  Wishbone slave responses.

Function
REQ-013 SHALL map letters A P Z L G I T Y E O X U K S V N (either case) to nibbles 0..15 in that order.
REQ-014 SHALL, in state COLLECT, store up to 8 nibbles; any other non-terminator character sets a sticky bad flag; a 9th letter sets it too.
REQ-015 SHALL treat 0x0A or 0x0D as terminator; terminator with zero letters stored is ignored (no pulse).
REQ-016 SHALL on terminator go to DECODE if count is 6 or 8 and bad flag clear; else pulse o_error one cycle later, clear buffer/flag, stay in COLLECT.
REQ-017 SHALL assert o_char_ready only in COLLECT.
REQ-018 SHALL decode address = 0x8000 | (n3&7)<<12 | (n5&7)<<8 | (n4&8)<<8 | (n2&7)<<4 | (n1&8)<<4 | (n4&7) | (n3&8).
REQ-019 SHALL decode replace = (n1&7)<<4 | (n0&8)<<4 | (n0&7) | (nL&8), nL = n5 for 6 letters, n7 for 8.
REQ-020 SHALL for 8 letters decode compare = (n7&7)<<4 | (n6&8)<<4 | (n6&7) | (n5&8) with compare-enable 1; 6 letters give compare 0, enable 0.
REQ-021 SHALL pack o_wb_odata: [111:104] slot (1..4), [96] compare-enable, [79:64] address, [39:32] compare, [7:0] replace, all other bits 0; o_wb_addr = 2'h1, o_wb_we = 1 during the cycle.
REQ-022 SHALL take one cycle in DECODE, then enter REQ with o_wb_cyc=o_wb_stb=1, data/address stable.
REQ-023 SHALL hold o_wb_stb until a cycle with i_wb_stall=0, then drop stb and enter WAIT with cyc held.
REQ-024 SHALL accept i_wb_ack or i_wb_err in the same cycle the request is accepted (skip WAIT).
REQ-025 SHALL on ack: drop cyc, pulse o_done, set o_cheats_loaded, advance slot 1->2->3->4->1, return to COLLECT.
REQ-026 SHALL on i_wb_err, or TIMEOUT cycles in WAIT without response: drop cyc, pulse o_error, keep slot, return to COLLECT; ack and err together count as err.
REQ-027 SHALL honour i_clear in any state for slot/loaded only; in-flight transaction completes and, if acked, uses its original slot then advances from 1.
REQ-028 SHALL never assert o_done and o_error in the same cycle.

Reset
REQ-029 SHALL on i_reset_n low immediately force COLLECT, buffer empty, bad flag 0, slot 1, o_wb_cyc/stb/we 0, o_wb_odata 0, o_done/o_error/o_cheats_loaded 0; o_char_ready 1 after release.
REQ-030 SHALL abandon an in-flight Wishbone cycle on reset with no o_done/o_error pulse.

Verification
REQ-031 "GOSSIP"+0x0A, immediate ack -> odata slot 1, enable 0, addr 0xD1DD, compare 0x00, replace 0x14; o_done pulse; slot 2.
REQ-032 "gossipap"+0x0D -> slot byte 1, enable 1, addr 0xD1DD, compare 0x10, replace 0x14.
REQ-033 "GOSSI"+0x0A, then "GOSSBP"+0x0A -> two o_error pulses, no o_wb_cyc, slot unchanged.
REQ-034 i_wb_stall high 3 cycles -> stb held 3 cycles, accepted on 4th; then no ack for TIMEOUT=16 cycles -> o_error, cyc low, slot unchanged.
REQ-035 five valid codes all acked -> slot bytes 1,2,3,4,1; i_clear after third -> next slot byte 1, o_cheats_loaded low until next ack.
REQ-036 reset asserted in WAIT -> cyc/stb low same cycle, no pulses, next code uses slot 1.
